// File: rtl/six_one_mux_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// six_one_mux_rr_arbiter_if
// Purpose : groups the request/grant bus of the six-source round-robin
//           arbiter that sits in front of six_one_MUX.
// Signals :
//   req_i      [5:0]            request per source (bit k = mux input dk)
//   req_mask_i [5:0]            per-source disable, only with ARB_REQ_MASK_EN
//   gnt_o      [5:0]            one-hot grant, zero when idle
//   sel_o      [2:0]            encoded mux select, 0..5
//   valid_o                     grant active
//   hold_o     [HOLD_CNT_W-1:0] cycles the current grant has been held
// Modports:
//   master - requester side (drives requests, observes grants)
//   slave  - arbiter side
// Optional feature macro: ARB_REQ_MASK_EN
// ---------------------------------------------------------------------------
interface six_one_mux_rr_arbiter_if #(
  parameter int HOLD_CNT_W = 4
);
  logic [5:0]            req_i;
`ifdef ARB_REQ_MASK_EN
  logic [5:0]            req_mask_i;
`endif
  logic [5:0]            gnt_o;
  logic [2:0]            sel_o;
  logic                  valid_o;
  logic [HOLD_CNT_W-1:0] hold_o;

`ifdef ARB_REQ_MASK_EN
  modport master (output req_i, output req_mask_i,
                  input gnt_o, input sel_o, input valid_o, input hold_o);
  modport slave  (input req_i, input req_mask_i,
                  output gnt_o, output sel_o, output valid_o, output hold_o);
`else
  modport master (output req_i,
                  input gnt_o, input sel_o, input valid_o, input hold_o);
  modport slave  (input req_i,
                  output gnt_o, output sel_o, output valid_o, output hold_o);
`endif
endinterface

// File: rtl/six_one_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// six_one_mux_rr_arbiter
// Purpose : round-robin arbiter/sequencer sharing the six_one_MUX datapath
//           between six requesters. One grant at a time, registered one cycle
//           after the request is sampled, bounded by MAX_HOLD cycles so no
//           source starves. sel_o drives the mux select directly.
// Ports   :
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high
//   bus    - six_one_mux_rr_arbiter_if.slave (req_i, [req_mask_i],
//            gnt_o, sel_o, valid_o, hold_o)
// Parameters:
//   MAX_HOLD   - max consecutive cycles one source may hold a grant
//                (1 .. 2**HOLD_CNT_W-1)
//   HOLD_CNT_W - hold counter width (must match the interface)
// Optional feature macro: ARB_REQ_MASK_EN (adds req_mask_i; a 1 disables
//   that source, and masking the current winner releases its grant).
// ---------------------------------------------------------------------------
module six_one_mux_rr_arbiter #(
  parameter int MAX_HOLD   = 8,
  parameter int HOLD_CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  six_one_mux_rr_arbiter_if.slave bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

  state_t                r_state, w_state_next;
  logic [5:0]            r_gnt,   w_gnt_next;
  logic [2:0]            r_sel,   w_sel_next;
  logic [2:0]            r_ptr,   w_ptr_next;
  logic [HOLD_CNT_W-1:0] r_hold,  w_hold_next;

  logic [5:0]            w_elig;
  logic [2:0]            w_cand_idx [6];
  logic [5:0]            w_cand_hit;
  logic [2:0]            w_win;
  logic                  w_any;
  logic                  w_keep;

`ifdef ARB_REQ_MASK_EN
  assign w_elig = bus.req_i & ~bus.req_mask_i;
`else
  assign w_elig = bus.req_i;
`endif

  // Candidate gi is source (ptr + gi) mod 6, so candidate 0 has the highest
  // priority. r_ptr only ever holds 0..5, so one conditional subtract suffices.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_cand
      logic [3:0] w_sum;
      assign w_sum          = {1'b0, r_ptr} + 4'(gi);
      assign w_cand_idx[gi] = (w_sum >= 4'd6) ? 3'(w_sum - 4'd6) : w_sum[2:0];
      assign w_cand_hit[gi] = w_elig[w_cand_idx[gi]];
    end
  endgenerate

  // Lowest-numbered hit candidate wins; scanning downward lets it overwrite.
  always_comb begin
    w_any = 1'b0;
    w_win = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (w_cand_hit[i]) begin
        w_any = 1'b1;
        w_win = w_cand_idx[i];
      end
    end
  end

  // Current winner keeps the grant while still eligible and under its budget.
  // Any other GRANT cycle is a release and re-arbitrates in the same cycle,
  // with ptr already past the winner so a timed-out source ranks last.
  assign w_keep = (r_state == ST_GRANT) && w_elig[r_sel] && (r_hold < HOLD_LAST);

  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_sel_next   = r_sel;
    w_ptr_next   = r_ptr;
    w_hold_next  = r_hold;
    if (w_keep) begin
      w_hold_next = r_hold + HOLD_CNT_W'(1);
    end else if (w_any) begin
      w_state_next = ST_GRANT;
      w_gnt_next   = 6'(1) << w_win;
      w_sel_next   = w_win;
      w_ptr_next   = (w_win == 3'd5) ? 3'd0 : w_win + 3'd1;
      w_hold_next  = '0;
    end else begin
      // Idle: sel_o parks on the last winner so the mux input stays stable.
      w_state_next = ST_IDLE;
      w_gnt_next   = '0;
      w_hold_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_sel   <= w_sel_next;
      r_ptr   <= w_ptr_next;
      r_hold  <= w_hold_next;
    end
  end

  assign bus.gnt_o   = r_gnt;
  assign bus.sel_o   = r_sel;
  assign bus.valid_o = (r_state == ST_GRANT);
  assign bus.hold_o  = r_hold;

endmodule

// File: tb/tb_six_one_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_six_one_mux_rr_arbiter
// Directed bench for six_one_mux_rr_arbiter. dut8 uses MAX_HOLD=8, dut1 uses
// MAX_HOLD=1. Inputs change and outputs are sampled 1 ns after a rising edge.
// Optional feature macro: ARB_REQ_MASK_EN.
// ---------------------------------------------------------------------------
module tb_six_one_mux_rr_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  six_one_mux_rr_arbiter_if #(.HOLD_CNT_W(4)) bus8 ();
  six_one_mux_rr_arbiter_if #(.HOLD_CNT_W(4)) bus1 ();

  six_one_mux_rr_arbiter #(.MAX_HOLD(8), .HOLD_CNT_W(4)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  six_one_mux_rr_arbiter #(.MAX_HOLD(1), .HOLD_CNT_W(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus8.req_i = 6'b0;
    bus1.req_i = 6'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus8.req_i = 6'b111111;
    tick();
    tick();
    vectors++;
    if (bus8.gnt_o !== 6'b0 || bus8.sel_o !== 3'd0 || bus8.valid_o !== 1'b0 || bus8.hold_o !== 4'd0) begin
      miscompares++;
      $display("FAIL reset: gnt=%b sel=%0d valid=%b hold=%0d, required 000000 0 0 0",
               bus8.gnt_o, bus8.sel_o, bus8.valid_o, bus8.hold_o);
    end
    $display("reset: gnt=%b sel=%0d valid=%b hold=%0d", bus8.gnt_o, bus8.sel_o, bus8.valid_o, bus8.hold_o);
    bus8.req_i = 6'b0;
    reset = 1'b0;
    tick();
  endtask

  // Source 2 requests for 3 edges: granted one cycle later for 3 cycles,
  // then idle with sel parked at 2. Leaves ptr = 3.
  task automatic test_single();
    do_reset();
    bus8.req_i = 6'b000100;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (bus8.gnt_o !== 6'b000100 || bus8.sel_o !== 3'd2 || bus8.valid_o !== 1'b1 || bus8.hold_o !== 4'(c)) begin
        miscompares++;
        $display("FAIL single c%0d: gnt=%b sel=%0d valid=%b hold=%0d, required 000100 2 1 %0d",
                 c, bus8.gnt_o, bus8.sel_o, bus8.valid_o, bus8.hold_o, c);
      end
      $display("single c%0d: gnt=%b sel=%0d hold=%0d", c, bus8.gnt_o, bus8.sel_o, bus8.hold_o);
    end
    bus8.req_i = 6'b0;
    tick();
    vectors++;
    if (bus8.gnt_o !== 6'b0 || bus8.valid_o !== 1'b0 || bus8.sel_o !== 3'd2) begin
      miscompares++;
      $display("FAIL single_idle: gnt=%b valid=%b sel=%0d, required 000000 0 2",
               bus8.gnt_o, bus8.valid_o, bus8.sel_o);
    end
    $display("single idle: gnt=%b valid=%b sel=%0d", bus8.gnt_o, bus8.valid_o, bus8.sel_o);
  endtask

  // Runs right after test_single (ptr = 3): 000011 wraps to source 0, then
  // dropping bit 0 hands over to source 1 with no bubble (ptr -> 2).
  // Then 100010 from ptr=2 must pick source 5, not 1.
  task automatic test_wrap();
    bus8.req_i = 6'b000011;
    tick();
    vectors++;
    if (bus8.gnt_o !== 6'b000001 || bus8.sel_o !== 3'd0 || bus8.valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_src0: gnt=%b sel=%0d valid=%b, required 000001 0 1",
               bus8.gnt_o, bus8.sel_o, bus8.valid_o);
    end
    $display("wrap src0: gnt=%b sel=%0d", bus8.gnt_o, bus8.sel_o);
    bus8.req_i = 6'b000010;
    tick();
    vectors++;
    if (bus8.gnt_o !== 6'b000010 || bus8.sel_o !== 3'd1 || bus8.valid_o !== 1'b1 || bus8.hold_o !== 4'd0) begin
      miscompares++;
      $display("FAIL wrap_src1: gnt=%b sel=%0d valid=%b hold=%0d, required 000010 1 1 0",
               bus8.gnt_o, bus8.sel_o, bus8.valid_o, bus8.hold_o);
    end
    $display("wrap src1: gnt=%b sel=%0d", bus8.gnt_o, bus8.sel_o);
    bus8.req_i = 6'b0;
    tick();
    bus8.req_i = 6'b100010;
    tick();
    vectors++;
    if (bus8.gnt_o !== 6'b100000 || bus8.sel_o !== 3'd5) begin
      miscompares++;
      $display("FAIL rotate_ptr2: gnt=%b sel=%0d, required 100000 5", bus8.gnt_o, bus8.sel_o);
    end
    $display("rotate ptr2: gnt=%b sel=%0d", bus8.gnt_o, bus8.sel_o);
    bus8.req_i = 6'b0;
    tick();
  endtask

  // All six request from reset: 0,1,2,3,4,5,0,... for exactly 8 cycles each.
  task automatic test_all_req();
    logic [5:0] e_gnt;
    int         e_src;
    do_reset();
    bus8.req_i = 6'b111111;
    for (int k = 0; k < 56; k++) begin
      tick();
      e_src = (k / 8) % 6;
      e_gnt = 6'b000001 << e_src;
      vectors++;
      if (bus8.gnt_o !== e_gnt || bus8.sel_o !== 3'(e_src) || bus8.valid_o !== 1'b1 || bus8.hold_o !== 4'(k % 8)) begin
        miscompares++;
        $display("FAIL all_req k%0d: gnt=%b sel=%0d valid=%b hold=%0d, required %b %0d 1 %0d",
                 k, bus8.gnt_o, bus8.sel_o, bus8.valid_o, bus8.hold_o, e_gnt, e_src, k % 8);
      end
      $display("all_req k%0d: gnt=%b sel=%0d hold=%0d", k, bus8.gnt_o, bus8.sel_o, bus8.hold_o);
    end
    bus8.req_i = 6'b0;
    tick();
  endtask

  // Source 5 granted up to hold=4, reset pulsed: grant dropped at once.
  task automatic test_reset_mid_grant();
    do_reset();
    bus8.req_i = 6'b100000;
    for (int k = 0; k < 5; k++) tick();
    vectors++;
    if (bus8.gnt_o !== 6'b100000 || bus8.sel_o !== 3'd5 || bus8.hold_o !== 4'd4) begin
      miscompares++;
      $display("FAIL mid_pre: gnt=%b sel=%0d hold=%0d, required 100000 5 4",
               bus8.gnt_o, bus8.sel_o, bus8.hold_o);
    end
    $display("mid pre: gnt=%b sel=%0d hold=%0d", bus8.gnt_o, bus8.sel_o, bus8.hold_o);
    reset = 1'b1;
    tick();
    vectors++;
    if (bus8.gnt_o !== 6'b0 || bus8.valid_o !== 1'b0 || bus8.sel_o !== 3'd0 || bus8.hold_o !== 4'd0) begin
      miscompares++;
      $display("FAIL mid_reset: gnt=%b valid=%b sel=%0d hold=%0d, required 000000 0 0 0",
               bus8.gnt_o, bus8.valid_o, bus8.sel_o, bus8.hold_o);
    end
    $display("mid reset: gnt=%b valid=%b sel=%0d", bus8.gnt_o, bus8.valid_o, bus8.sel_o);
    reset = 1'b0;
    bus8.req_i = 6'b100001;
    tick();
    vectors++;
    if (bus8.gnt_o !== 6'b000001 || bus8.sel_o !== 3'd0 || bus8.valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_after: gnt=%b sel=%0d valid=%b, required 000001 0 1",
               bus8.gnt_o, bus8.sel_o, bus8.valid_o);
    end
    $display("mid after: gnt=%b sel=%0d", bus8.gnt_o, bus8.sel_o);
    bus8.req_i = 6'b0;
    tick();
  endtask

  // Only source 4 requests: it re-wins at each timeout, hold wraps 7->0.
  task automatic test_timeout_solo();
    do_reset();
    bus8.req_i = 6'b010000;
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if (bus8.gnt_o !== 6'b010000 || bus8.sel_o !== 3'd4 || bus8.valid_o !== 1'b1 || bus8.hold_o !== 4'(k % 8)) begin
        miscompares++;
        $display("FAIL timeout k%0d: gnt=%b sel=%0d valid=%b hold=%0d, required 010000 4 1 %0d",
                 k, bus8.gnt_o, bus8.sel_o, bus8.valid_o, bus8.hold_o, k % 8);
      end
      $display("timeout k%0d: gnt=%b hold=%0d", k, bus8.gnt_o, bus8.hold_o);
    end
    bus8.req_i = 6'b0;
    tick();
  endtask

  // MAX_HOLD=1: continuous requesters rotate every cycle, hold stays 0.
  task automatic test_max_hold_one();
    logic [5:0] e_gnt;
    do_reset();
    bus1.req_i = 6'b111111;
    for (int k = 0; k < 14; k++) begin
      tick();
      e_gnt = 6'b000001 << (k % 6);
      vectors++;
      if (bus1.gnt_o !== e_gnt || bus1.sel_o !== 3'(k % 6) || bus1.valid_o !== 1'b1 || bus1.hold_o !== 4'd0) begin
        miscompares++;
        $display("FAIL hold1 k%0d: gnt=%b sel=%0d valid=%b hold=%0d, required %b %0d 1 0",
                 k, bus1.gnt_o, bus1.sel_o, bus1.valid_o, bus1.hold_o, e_gnt, k % 6);
      end
      $display("hold1 k%0d: gnt=%b sel=%0d", k, bus1.gnt_o, bus1.sel_o);
    end
    bus1.req_i = 6'b0;
    tick();
  endtask

  // Source 1 granted, then 001010 arrives. With the mask on source 1 the
  // grant moves to source 3 next edge; without the mask source 1 keeps it.
  task automatic test_mask();
    do_reset();
    bus8.req_i = 6'b000010;
    tick();
    vectors++;
    if (bus8.gnt_o !== 6'b000010 || bus8.sel_o !== 3'd1) begin
      miscompares++;
      $display("FAIL mask_pre: gnt=%b sel=%0d, required 000010 1", bus8.gnt_o, bus8.sel_o);
    end
    bus8.req_i = 6'b001010;
`ifdef ARB_REQ_MASK_EN
    bus8.req_mask_i = 6'b000010;
    tick();
    vectors++;
    if (bus8.gnt_o !== 6'b001000 || bus8.sel_o !== 3'd3 || bus8.valid_o !== 1'b1 || bus8.hold_o !== 4'd0) begin
      miscompares++;
      $display("FAIL mask_move: gnt=%b sel=%0d valid=%b hold=%0d, required 001000 3 1 0",
               bus8.gnt_o, bus8.sel_o, bus8.valid_o, bus8.hold_o);
    end
    bus8.req_mask_i = 6'b0;
`else
    tick();
    vectors++;
    if (bus8.gnt_o !== 6'b000010 || bus8.sel_o !== 3'd1 || bus8.valid_o !== 1'b1 || bus8.hold_o !== 4'd1) begin
      miscompares++;
      $display("FAIL no_mask_hold: gnt=%b sel=%0d valid=%b hold=%0d, required 000010 1 1 1",
               bus8.gnt_o, bus8.sel_o, bus8.valid_o, bus8.hold_o);
    end
`endif
    $display("mask: gnt=%b sel=%0d hold=%0d", bus8.gnt_o, bus8.sel_o, bus8.hold_o);
    bus8.req_i = 6'b0;
    tick();
  endtask

  initial begin
    bus8.req_i = 6'b0;
    bus1.req_i = 6'b0;
`ifdef ARB_REQ_MASK_EN
    bus8.req_mask_i = 6'b0;
    bus1.req_mask_i = 6'b0;
`endif
    test_reset();
    test_single();
    test_wrap();
    test_all_req();
    test_reset_mid_grant();
    test_timeout_solo();
    test_max_hold_one();
    test_mask();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
